// File: rtl/matrix_multiplier_core.sv
// matrix_multiplier_core: 2x2 output-stationary systolic array computing C = A(2xK) * B(Kx2).
module matrix_multiplier_core (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [16:0] size,
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    output logic        valid,
    output logic        c11ready,
    output logic        c12ready,
    output logic        c21ready,
    output logic        c22ready,
    output logic [31:0] C11,
    output logic [31:0] C12,
    output logic [31:0] C21,
    output logic [31:0] C22
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]  state;
    logic [16:0] k, cnt;
    logic [31:0] a1, a2, b1, b2;
    logic [31:0] a1_d, a2_d, b1_d, b2_d, a2_dd, b2_dd;
    logic        s1, s2;
    assign a1 = {{16{inA[15]}}, inA[15:0]};
    assign a2 = {{16{inA[31]}}, inA[31:16]};
    assign b1 = {{16{inB[15]}}, inB[15:0]};
    assign b2 = {{16{inB[31]}}, inB[31:16]};
    // Skew stages: s1 marks a beat one cycle old (PE12/PE21), s2 two cycles old (PE22).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            {a1_d, a2_d, b1_d, b2_d, a2_dd, b2_dd} <= '0;
            {s1, s2} <= '0;
            {C11, C12, C21, C22} <= '0;
            {valid, c11ready, c12ready, c21ready, c22ready} <= '0;
        end else begin
            s1 <= state == LOAD;
            s2 <= s1;
            {a1_d, a2_d, b1_d, b2_d} <= {a1, a2, b1, b2};
            {a2_dd, b2_dd} <= {a2_d, b2_d};
            if (s1) begin
                C12 <= C12 + a1_d * b2_d;
                C21 <= C21 + a2_d * b1_d;
            end
            if (s2) C22 <= C22 + a2_dd * b2_dd;
            case (state)
                LOAD: begin
                    C11 <= C11 + a1 * b1;
                    cnt <= cnt + 17'd1;
                    if (cnt == k - 17'd1) begin
                        c11ready <= 1'b1;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!c12ready) {c12ready, c21ready} <= 2'b11;
                    else begin
                        {c22ready, valid} <= 2'b11;
                        state <= DONE;
                    end
                end
                default: begin
                    if (start) begin
                        k <= size;
                        cnt <= '0;
                        {C11, C12, C21, C22} <= '0;
                        {valid, c11ready, c12ready, c21ready, c22ready} <= '0;
                        state <= size == 17'd0 ? DONE : LOAD;
                    end else if (state == DONE && !valid)
                        // Only an empty (K=0) run reaches DONE with flags low; raise them one cycle later.
                        {valid, c11ready, c12ready, c21ready, c22ready} <= '1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_multiplier_core.sv
// tb_matrix_multiplier_core: directed scenario tests for the 2x2 systolic matrix multiplier.
module tb_matrix_multiplier_core;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [16:0] size = '0;
    logic [31:0] inA = '0, inB = '0;
    logic        valid, c11ready, c12ready, c21ready, c22ready;
    logic [31:0] C11, C12, C21, C22;
    logic [31:0] va[4], vb[4];
    int n_chk = 0, n_fail = 0;

    matrix_multiplier_core dut (
        .clk(clk), .reset_n(reset_n), .start(start), .size(size), .inA(inA), .inB(inB),
        .valid(valid), .c11ready(c11ready), .c12ready(c12ready), .c21ready(c21ready),
        .c22ready(c22ready), .C11(C11), .C12(C12), .C21(C21), .C22(C22)
    );

    always #5 clk = ~clk;

    // Issues start at E0 and the k beats; returns just after E(k). A second start pulses during beat glitch.
    task automatic feed(input int kk, input int glitch);
        @(negedge clk);
        start = 1'b1;
        size = 17'(kk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < kk; i++) begin
            inA = va[i];
            inB = vb[i];
            start = (i == glitch);
            @(negedge clk);
        end
        start = 1'b0;
        inA = $urandom;
        inB = $urandom;
    endtask

    task automatic test_reset;
        #2;
        n_chk++; if ({valid, c11ready, c12ready, c21ready, c22ready} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {valid, c11ready, c12ready, c21ready, c22ready}); end
        n_chk++; if ({C11, C12, C21, C22} !== 128'b0) begin n_fail++; $display("FAIL reset_c: got %h want 0", {C11, C12, C21, C22}); end
        @(negedge clk);
        reset_n = 1'b1;
        inA = $urandom;
        inB = $urandom;
        repeat (3) @(negedge clk);
        n_chk++; if (valid !== 1'b0 || C11 !== 32'd0) begin n_fail++; $display("FAIL idle_wait: got valid=%b C11=%h want 0 0", valid, C11); end
    endtask

    task automatic test_k4(input string tag, input int glitch);
        for (int i = 0; i < 4; i++) begin
            va[i] = {16'(5 + i), 16'(1 + i)};
            vb[i] = {16'(1 + i), 16'd1};
        end
        feed(4, glitch);
        n_chk++; if ({c11ready, c12ready, c21ready, c22ready, valid} !== 5'b10000) begin n_fail++; $display("FAIL %s_e4_flags: got %b want 10000", tag, {c11ready, c12ready, c21ready, c22ready, valid}); end
        n_chk++; if (C11 !== 32'd10 || C12 !== 32'd14) begin n_fail++; $display("FAIL %s_e4_c: got C11=%0d C12=%0d want 10 14", tag, C11, C12); end
        @(negedge clk);
        n_chk++; if ({c11ready, c12ready, c21ready, c22ready, valid} !== 5'b11100) begin n_fail++; $display("FAIL %s_e5_flags: got %b want 11100", tag, {c11ready, c12ready, c21ready, c22ready, valid}); end
        n_chk++; if (C12 !== 32'd30 || C21 !== 32'd26 || C22 !== 32'd38) begin n_fail++; $display("FAIL %s_e5_c: got C12=%0d C21=%0d C22=%0d want 30 26 38", tag, C12, C21, C22); end
        @(negedge clk);
        n_chk++; if ({c11ready, c12ready, c21ready, c22ready, valid} !== 5'b11111) begin n_fail++; $display("FAIL %s_e6_flags: got %b want 11111", tag, {c11ready, c12ready, c21ready, c22ready, valid}); end
        n_chk++; if ({C11, C12, C21, C22} !== {32'd10, 32'd30, 32'd26, 32'd70}) begin n_fail++; $display("FAIL %s_e6_c: got %0d %0d %0d %0d want 10 30 26 70", tag, C11, C12, C21, C22); end
        inA = $urandom;
        inB = $urandom;
        @(negedge clk);
        n_chk++; if (valid !== 1'b1 || C11 !== 32'd10 || C22 !== 32'd70) begin n_fail++; $display("FAIL %s_hold: got valid=%b C11=%0d C22=%0d want 1 10 70", tag, valid, C11, C22); end
    endtask

    task automatic test_k1;
        va[0] = {16'h0002, 16'hFFFD};
        vb[0] = {16'hFFFB, 16'h0004};
        feed(1, -1);
        n_chk++; if (c11ready !== 1'b1 || C11 !== -32'sd12) begin n_fail++; $display("FAIL k1_e1: got rdy=%b C11=%h want 1 fffffff4", c11ready, C11); end
        @(negedge clk);
        n_chk++; if (valid !== 1'b0 || {c12ready, c21ready} !== 2'b11) begin n_fail++; $display("FAIL k1_e2: got valid=%b c12/c21=%b want 0 11", valid, {c12ready, c21ready}); end
        @(negedge clk);
        n_chk++; if (valid !== 1'b1 || c22ready !== 1'b1) begin n_fail++; $display("FAIL k1_e3_valid: got %b%b want 11", valid, c22ready); end
        n_chk++; if ({C11, C12, C21, C22} !== {-32'sd12, 32'sd15, 32'sd8, -32'sd10}) begin n_fail++; $display("FAIL k1_c: got %h %h %h %h want fffffff4 f 8 fffffff6", C11, C12, C21, C22); end
    endtask

    task automatic test_wrap;
        va[0] = {16'h0001, 16'h8000};
        va[1] = va[0];
        vb[0] = {16'h0001, 16'h8000};
        vb[1] = vb[0];
        feed(2, -1);
        repeat (2) @(negedge clk);
        n_chk++; if (valid !== 1'b1 || C11 !== 32'h8000_0000) begin n_fail++; $display("FAIL wrap_c11: got valid=%b C11=%h want 1 80000000", valid, C11); end
        n_chk++; if ({C12, C21, C22} !== {32'hFFFF_0000, 32'hFFFF_0000, 32'd2}) begin n_fail++; $display("FAIL wrap_others: got %h %h %h want ffff0000 ffff0000 2", C12, C21, C22); end
    endtask

    task automatic test_k0;
        feed(0, -1);
        n_chk++; if (valid !== 1'b0 || C11 !== 32'd0) begin n_fail++; $display("FAIL k0_e0: got valid=%b C11=%h want 0 0", valid, C11); end
        @(negedge clk);
        n_chk++; if ({c11ready, c12ready, c21ready, c22ready, valid} !== 5'b11111) begin n_fail++; $display("FAIL k0_flags: got %b want 11111", {c11ready, c12ready, c21ready, c22ready, valid}); end
        n_chk++; if ({C11, C12, C21, C22} !== 128'b0) begin n_fail++; $display("FAIL k0_c: got %h want 0", {C11, C12, C21, C22}); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 4; i++) begin
            va[i] = {16'(5 + i), 16'(1 + i)};
            vb[i] = {16'(1 + i), 16'd1};
        end
        feed(2, -1);
        n_chk++; if (C11 !== 32'd3) begin n_fail++; $display("FAIL mid_partial: got C11=%0d want 3", C11); end
        inA = va[2];
        inB = vb[2];
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if ({C11, C12, C21, C22} !== 128'b0 || {valid, c11ready, c12ready, c21ready, c22ready} !== 5'b0) begin n_fail++; $display("FAIL mid_async: got %h flags=%b want 0 00000", {C11, C12, C21, C22}, {valid, c11ready, c12ready, c21ready, c22ready}); end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_chk++; if ({C11, C12, C21, C22} !== 128'b0 || c11ready !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL mid_aborted: got %h rdy=%b valid=%b want 0 0 0", {C11, C12, C21, C22}, c11ready, valid); end
        test_k4("after_reset", -1);
    endtask

    task automatic test_start_ignored;
        test_k4("restart", 1);
        @(negedge clk);
        start = 1'b1;
        size = 17'd4;
        @(negedge clk);
        start = 1'b0;
        n_chk++; if ({valid, c11ready, c12ready, c21ready, c22ready} !== 5'b0) begin n_fail++; $display("FAIL restart_flags: got %b want 00000", {valid, c11ready, c12ready, c21ready, c22ready}); end
        n_chk++; if ({C11, C12, C21, C22} !== 128'b0) begin n_fail++; $display("FAIL restart_c: got %h want 0", {C11, C12, C21, C22}); end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_k4("k4", -1);
        test_k1();
        test_wrap();
        test_k0();
        test_reset_mid();
        test_start_ignored();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
